// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared types and constants for the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic [0:0] {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam logic [3:0] MEM_BE_FULL = 4'hF;

    function automatic logic is_busy(input arb_state_t s);
        return (s == BUSY_I) || (s == BUSY_D);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : arb_watchdog
// Brief    : Counts stalled cycles of a memory transaction; flags expiry.
// Revision : 1.0 - initial release
// ============================================================================
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, run, clear};
            assign expired       = 1'b0;
        end else begin : g_enabled
            localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] count_q;
            logic [CNT_W-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (clear) begin
                    count_d = '0;
                end else if (run && (count_q != CNT_LAST)) begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            // Expires during the TIMEOUT-th consecutive stalled cycle.
            assign expired = run && (count_q == CNT_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory bus between fetch and data; data-first with
//            a starvation guard and per-transaction watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned STREAK_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_t          state_q,     state_d;
    grant_t              grant_q,     grant_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [31:0]         mem_addr_q,  mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_be_q,    mem_be_d;
    logic [31:0]         if_rdata_q,  if_rdata_d;
    logic [31:0]         d_rdata_q,   d_rdata_d;
    logic                if_valid_q,  if_valid_d;
    logic                if_err_q,    if_err_d;
    logic                d_valid_q,   d_valid_d;
    logic                d_err_q,     d_err_d;

    logic busy;
    logic grant_d_port;
    logic wd_expired;

    assign busy         = is_busy(state_q);
    assign grant_d_port = d_req && !(if_req && (streak_q == STREAK_MAX));

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .run     (busy && !mem_ready),
        .clear   (!busy),
        .expired (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        if_err_d    = 1'b0;
        d_valid_d   = 1'b0;
        d_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!if_req) begin
                    streak_d = '0;
                end
                if (grant_d_port) begin
                    state_d     = BUSY_D;
                    grant_d     = GRANT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_we ? d_be : MEM_BE_FULL;
                    // A data grant with fetch pending implies streak is below the cap.
                    if (if_req) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end else if (if_req) begin
                    state_d     = BUSY_I;
                    grant_d     = GRANT_I;
                    streak_d    = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = MEM_BE_FULL;
                end
            end

            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (grant_q == GRANT_I) begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                        d_valid_d = 1'b1;
                    end
                end else if (wd_expired) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (grant_q == GRANT_I) begin
                        if_rdata_d = '0;
                        if_valid_d = 1'b1;
                        if_err_d   = 1'b1;
                    end else begin
                        d_rdata_d = '0;
                        d_valid_d = 1'b1;
                        d_err_d   = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= GRANT_I;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            d_valid_q   <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            if_err_q    <= if_err_d;
            d_valid_q   <= d_valid_d;
            d_err_q     <= d_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign if_err    = if_err_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign d_err     = d_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter (MAX_D_STREAK=4, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    mem_port_arbiter #(
        .MAX_D_STREAK (MAXS),
        .TIMEOUT      (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: per-port read data, data streak, grant log.
    int          m_streak;
    logic [31:0] m_if_rd;
    logic [31:0] m_d_rd;
    string       obs;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          lat;        // BUSY cycle carrying mem_ready, 0 = never
        bit          exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_cycles; // cycles mem_req stays high
    } vec_t;

    vec_t vecs[11];

    task automatic run_vec(input int idx, input vec_t v);
        int k;
        @(negedge clk);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        @(negedge clk);
        chk($sformatf("v%0d mem_req", idx), mem_req, 1);
        chk($sformatf("v%0d mem_addr", idx), mem_addr, v.addr);
        chk($sformatf("v%0d mem_we", idx), mem_we, v.exp_we);
        chk($sformatf("v%0d mem_be", idx), mem_be, v.exp_be);
        if (v.exp_we) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            k = i;
            mem_ready = (i == v.lat);
            mem_rdata = (i == v.lat) ? v.rdata : $urandom;
            @(negedge clk);
            mem_ready = 1'b0;
            if (!mem_req) break;
        end
        chk($sformatf("v%0d busy_cycles", idx), k, v.exp_cycles);
        chk($sformatf("v%0d valid", idx), {if_valid, d_valid}, v.is_d ? 2'b01 : 2'b10);
        chk($sformatf("v%0d err", idx), v.is_d ? d_err : if_err, v.exp_err);
        chk($sformatf("v%0d rdata", idx), v.is_d ? d_rdata : if_rdata, v.exp_rdata);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d pulse_end", idx), {mem_req, if_valid, d_valid}, 0);
    endtask

    // Randomised traffic checked against a transaction-level model of the arbiter.
    task automatic engine(input int ncyc, input int preq, input int latmax, input bit log_g);
        bit          busy, free, g_d, dropped, ip, dp, irl, drl;
        int          t_dec, lat, bb, k;
        logic [31:0] ia, da, dw, e_addr;
        logic        dwe, e_we, e_err;
        logic [3:0]  dbe, e_be;
        busy = 0; g_d = 0; dropped = 0; ip = 0; dp = 0;
        t_dec = 0; lat = 0; bb = 0;
        ia = 0; da = 0; dw = 0; e_addr = 0; dwe = 0; e_we = 0; e_err = 0; dbe = 0; e_be = 0;
        for (int c = 0; c < ncyc + 400; c++) begin
            @(negedge clk);
            free = !busy;
            k = c - t_dec;
            if (busy && k <= bb) begin
                chk("eng mem_req_busy", mem_req, 1);
                chk("eng valid_busy", {if_valid, d_valid}, 0);
                if (k == 1) begin
                    chk("eng mem_addr", mem_addr, e_addr);
                    chk("eng mem_we", mem_we, e_we);
                    chk("eng mem_be", mem_be, e_be);
                    if (log_g) obs = {obs, (mem_addr[31:28] == 4'h2) ? "D" : "I"};
                end
            end else if (busy) begin
                chk("eng mem_req_done", mem_req, 0);
                chk("eng valid_done", {if_valid, d_valid}, g_d ? 2'b01 : 2'b10);
                chk("eng err", g_d ? d_err : if_err, e_err);
                chk("eng rdata", g_d ? d_rdata : if_rdata, g_d ? m_d_rd : m_if_rd);
                if (g_d) dp = 0; else ip = 0;
                dropped = 0;
                busy    = 0;
            end else begin
                chk("eng quiet", {mem_req, if_valid, d_valid}, 0);
            end

            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (busy && k == lat) begin
                mem_ready = 1'b1;
                if (!g_d) m_if_rd = mem_rdata;
                else if (!e_we) m_d_rd = mem_rdata;
            end

            if (c < ncyc) begin
                if (!ip && $urandom_range(99) < preq) begin
                    ip = 1; ia = {4'h1, 28'($urandom)};
                end
                if (!dp && $urandom_range(99) < preq) begin
                    dp = 1; dwe = 1'($urandom_range(1)); da = {4'h2, 28'($urandom)};
                    dw = $urandom; dbe = 4'($urandom_range(15));
                end
            end
            if (busy && k == 2 && $urandom_range(3) == 0) dropped = 1;
            irl = ip && !(dropped && !g_d);
            drl = dp && !(dropped && g_d);
            if_req = irl; if_addr = ia;
            d_req = drl; d_we = dwe; d_addr = da; d_wdata = dw; d_be = dbe;

            if (free) begin
                if (!irl) m_streak = 0;
                if (irl || drl) begin
                    g_d = drl && !(irl && m_streak == MAXS);
                    if (!g_d) m_streak = 0;
                    else if (irl) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
                    busy   = 1;
                    t_dec  = c;
                    lat    = $urandom_range(latmax, 1);
                    bb     = (lat > TMO) ? TMO : lat;
                    e_addr = g_d ? da : ia;
                    e_we   = g_d && dwe;
                    e_be   = (g_d && dwe) ? dbe : 4'hF;
                    e_err  = (lat > TMO);
                    if (e_err) begin
                        if (g_d) m_d_rd = 0; else m_if_rd = 0;
                    end
                end
            end
            if (c >= ncyc && free && !busy && !ip && !dp) break;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        //         is_d we addr          wdata         be    rdata         lat we be    exp_rdata     err cyc
        vecs[0]  = '{0, 0, 32'h100,  32'h0,        4'h0, 32'h00500093, 1, 0, 4'hF, 32'h00500093, 0, 1};
        vecs[1]  = '{1, 0, 32'h2004, 32'h0,        4'h3, 32'h11223344, 3, 0, 4'hF, 32'h11223344, 0, 3};
        vecs[2]  = '{1, 1, 32'h2000, 32'hDEADBEEF, 4'h3, 32'hAAAA5555, 2, 1, 4'h3, 32'h11223344, 0, 2};
        vecs[3]  = '{1, 0, 32'h3000, 32'h0,        4'h5, 32'h99999999, 0, 0, 4'hF, 32'h0,        1, 8};
        vecs[4]  = '{1, 0, 32'h3004, 32'h0,        4'h0, 32'hCAFEF00D, 8, 0, 4'hF, 32'hCAFEF00D, 0, 8};
        vecs[5]  = '{1, 1, 32'h3008, 32'h01020304, 4'hC, 32'h77777777, 7, 1, 4'hC, 32'hCAFEF00D, 0, 7};
        vecs[6]  = '{1, 1, 32'h300C, 32'h0BADF00D, 4'hF, 32'h0,        0, 1, 4'hF, 32'h0,        1, 8};
        vecs[7]  = '{0, 0, 32'h104,  32'h0,        4'h0, 32'h0,        0, 0, 4'hF, 32'h0,        1, 8};
        vecs[8]  = '{0, 0, 32'h108,  32'h0,        4'h0, 32'h00000013, 9, 0, 4'hF, 32'h0,        1, 8};
        vecs[9]  = '{0, 0, 32'h10C,  32'h0,        4'h0, 32'h12345678, 5, 0, 4'hF, 32'h12345678, 0, 5};
        vecs[10] = '{1, 0, 32'h2008, 32'h0,        4'h1, 32'h5A5AA5A5, 2, 0, 4'hF, 32'h5A5AA5A5, 0, 2};

        rst = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mem_rdata = 0; mem_ready = 0;
        m_streak = 0; m_if_rd = 0; m_d_rd = 0; obs = "";
        #1;
        chk("rst mem_req", mem_req, 0);
        chk("rst valids", {if_valid, d_valid, if_err, d_err}, 0);
        chk("rst if_rdata", if_rdata, 0);
        chk("rst d_rdata", d_rdata, 0);
        chk("rst mem_be", mem_be, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Simultaneous requests: data store first, then fetch.
        @(negedge clk);
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        @(negedge clk);
        chk("sim d mem_req", mem_req, 1);
        chk("sim d mem_addr", mem_addr, 32'h2000);
        chk("sim d mem_we", mem_we, 1);
        chk("sim d mem_be", mem_be, 4'h3);
        chk("sim d mem_wdata", mem_wdata, 32'hDEADBEEF);
        mem_ready = 1; mem_rdata = 32'hFFFF0000;
        @(negedge clk);
        mem_ready = 0;
        chk("sim d valid", {if_valid, d_valid}, 2'b01);
        chk("sim d_rdata kept", d_rdata, 32'h5A5AA5A5);
        d_req = 0;
        @(negedge clk);
        chk("sim idle gap", mem_req, 0);
        @(negedge clk);
        chk("sim i mem_req", mem_req, 1);
        chk("sim i mem_addr", mem_addr, 32'h200);
        chk("sim i mem_we", mem_we, 0);
        chk("sim i mem_be", mem_be, 4'hF);
        mem_ready = 1; mem_rdata = 32'h00A00113;
        @(negedge clk);
        mem_ready = 0;
        chk("sim i valid", {if_valid, d_valid}, 2'b10);
        chk("sim i rdata", if_rdata, 32'h00A00113);
        if_req = 0;
        @(negedge clk);
        chk("sim i pulse_end", if_valid, 0);

        // Asynchronous reset in the middle of a data transaction.
        d_req = 1; d_we = 0; d_addr = 32'h4000; d_be = 4'hF;
        @(negedge clk);
        chk("ares busy", mem_req, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ares mem_req", mem_req, 0);
        chk("ares valids", {if_valid, d_valid}, 0);
        chk("ares if_rdata", if_rdata, 0);
        chk("ares d_rdata", d_rdata, 0);
        chk("ares mem_addr", mem_addr, 0);
        d_req = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("ares quiet", {mem_req, if_valid, d_valid}, 0);
        end
        m_streak = 0; m_if_rd = 0; m_d_rd = 0;

        // Both ports saturated: starvation guard pattern.
        obs = "";
        engine(200, 100, 1, 1'b1);
        n_checks++;
        if (obs.len() < 10 || obs.substr(0, 9) != "DDDDIDDDDI") begin
            n_err++;
            $display("FAIL starvation_order: got %s expected DDDDIDDDDI...", obs.substr(0, 9));
        end

        engine(3000, 40, 11, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory bus between instruction fetch (IF) and the data load/store path (D).
- Sits between the fetch unit, the MEM-stage load/store logic and the unified memory.
- Data has priority over fetch, with a starvation guard and a per-transaction watchdog timeout.

Parameters:
- MAX_D_STREAK, 4: maximum consecutive data grants while if_req is pending before fetch is forced.
- TIMEOUT, 64: BUSY cycles without mem_ready before the transaction is aborted with an error. 0 disables the timeout.

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  32  fetch address; stable while if_req is high.
- if_rdata  out  32  fetched instruction; valid with if_valid.
- if_valid  out  1  one-cycle completion pulse for fetch.
- if_err  out  1  fetch timed out; qualified by if_valid.
- d_req  in  1  data request; held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_be  in  4  store byte enables.
- d_rdata  out  32  load data; valid with d_valid.
- d_valid  out  1  one-cycle completion pulse for data.
- d_err  out  1  data access timed out; qualified by d_valid.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables; 4'hF for fetch and loads.
- mem_rdata  in  32  memory read data; sampled when mem_ready is high.
- mem_ready  in  1  memory completion; may arrive 1..N cycles after mem_req rises.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE; streak and timeout counters clear.
  - All outputs go to 0, including the rdata registers. mem_req drops immediately.
  - Any in-flight transaction is abandoned; no valid pulse follows reset.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE: samples requests.
  - d_req only: go to BUSY_D.
  - if_req only: go to BUSY_I.
  - Both pending: go to BUSY_D, unless streak == MAX_D_STREAK, in which case go to BUSY_I.
  - Neither: stay in IDLE.
  - On entry to BUSY_x, mem_* outputs are registered copies of the granted requester's address/data/we/be.
  - mem_req is high for every cycle spent in BUSY_x.
- BUSY_x with mem_ready == 1: go to DONE at that edge.
  - Fetch: latch mem_rdata into if_rdata.
  - Load: latch mem_rdata into d_rdata.
  - Store: d_rdata keeps its previous value.
  - mem_req drops at that edge.
- BUSY_x timeout: the timeout counter increments every BUSY cycle without mem_ready.
  - When it reaches TIMEOUT, go to DONE with err set.
  - The rdata register of that port is cleared to 0.
  - mem_ready and timeout landing in the same cycle: mem_ready wins, err = 0.
- DONE: lasts exactly one cycle.
  - The matching valid pulse (and err, if set) is asserted; then return to IDLE.
  - Requests are ignored in DONE, so a req still high at the next edge is a new request.
  - Minimum cost is therefore 3 cycles per transaction (IDLE, BUSY, DONE), with mem_ready in the first BUSY cycle.
- Streak counter (saturates at MAX_D_STREAK):
  - +1 on each D grant made while if_req is high.
  - Cleared on any I grant.
  - Cleared on any IDLE cycle with if_req low.
- Requester contract:
  - addr/data/we/be must stay stable while req is high.
  - Dropping req mid-transaction does not cancel it; a valid pulse still occurs.
- if_err and d_err are 0 whenever their valid is 0.

Decomposition:
- Shared riscv_pkg gets:
  - arb_state_t enum: IDLE, BUSY_I, BUSY_D, DONE.
  - grant_t enum: GRANT_I, GRANT_D.
  - Constant MEM_BE_FULL = 4'hF.
- One natural sub-module: arb_watchdog, a parameterised timeout counter.
  - Inputs: clk, rst, run, clear.
  - Output: expired.
  - Holds expired at 0 when TIMEOUT == 0.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100; mem_ready one cycle after mem_req → mem_addr=0x100, mem_be=F, mem_we=0; if_valid pulses once with if_rdata=mem_rdata (0x00500093); if_err=0.
- Simultaneous requests: if_req and d_req both high, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011 → D served first with mem_we=1, mem_be=3; IF served next; d_rdata unchanged.
- Starvation guard (MAX_D_STREAK=4): d_req and if_req held high continuously → grant order D,D,D,D,I,D…
- Timeout (TIMEOUT=8): d_req load, mem_ready never asserted → mem_req high for exactly 8 cycles; then d_valid=1, d_err=1, d_rdata=0; back in IDLE.
- Ready vs timeout same cycle: mem_ready asserted on the 8th BUSY cycle → d_err=0, data latched.
- Async reset mid-BUSY_D: rst pulsed between clock edges → mem_req, d_valid and if_valid go 0 immediately; after release, state is IDLE and no stale valid pulse appears.
